// File: rtl/cpu_guess_generator.sv
// cpu_guess_generator: picks the computer player's next unshot cell on each
// go request and presents it as a one-hot guess with a 1-cycle sel strobe.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   phase          1 = game mode; dropping it aborts and starts a new game
//   go             request one guess (sampled only while idle)
//   pships         player ship map (target mode only)
//   c_curr_guess   one-hot guess, nonzero only while sel = 1
//   sel            1-cycle strobe marking c_curr_guess valid
//   busy           searching or issuing
//   exhausted      every cell has been shot this game
//   last_idx       index of the most recently issued guess
//
// Optional feature: define TARGET_MODE_EN to queue the on-board neighbours
// of a hit cell and shoot them (lowest index first) before random search.
module cpu_guess_generator #(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 7,
    parameter logic [4:0]  LFSR_SEED = 5'b00001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 phase,
    input  logic                 go,
    input  logic [ROWS*COLS-1:0] pships,
    output logic [ROWS*COLS-1:0] c_curr_guess,
    output logic                 sel,
    output logic                 busy,
    output logic                 exhausted,
    output logic [4:0]           last_idx
);

    localparam int unsigned CELLS = ROWS * COLS;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        ISSUE
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       lfsr_q, lfsr_d;
    logic [4:0]       idx_q, idx_d;
    logic [4:0]       last_q, last_d;
    logic [CELLS-1:0] guessed_q, guessed_d;

    logic [4:0]       lfsr_nxt;
    logic [4:0]       cand;
    logic             cand_ok;
    logic [31:0]      guessed32;
    logic [CELLS-1:0] issue_oh;
    logic             use_pend;
    logic [4:0]       pend_idx;

    assign lfsr_nxt  = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    // LFSR never reaches 0, so lfsr-1 spans 0..30 and covers every cell
    assign cand      = lfsr_q - 5'd1;
    assign guessed32 = 32'(guessed_q);
    assign cand_ok   = (cand < 5'(CELLS)) && !guessed32[cand];
    assign issue_oh  = CELLS'(1) << idx_q;

    // Gating with phase keeps an ISSUE cycle from strobing once the game ends
    assign sel          = (state_q == ISSUE) && phase;
    assign c_curr_guess = sel ? issue_oh : '0;
    assign busy         = (state_q != IDLE);
    assign exhausted    = &guessed_q;
    assign last_idx     = last_q;

`ifdef TARGET_MODE_EN
    logic [CELLS-1:0] pending_q, pending_d;
    logic [CELLS-1:0] open_pend;
    logic [CELLS-1:0] nbr;
    logic [31:0]      pships32;
    int unsigned      col;

    assign pships32  = 32'(pships);
    assign open_pend = pending_q & ~guessed_q;
    assign use_pend  = |open_pend;

    always_comb begin
        pend_idx = '0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (open_pend[i]) pend_idx = 5'(i);
        end
    end

    always_comb begin
        col = 32'(idx_q) % COLS;
        nbr = '0;
        if (pships32[idx_q]) begin
            if (32'(idx_q) >= COLS)         nbr = nbr | (issue_oh >> COLS);
            if (32'(idx_q) + COLS < CELLS)  nbr = nbr | (issue_oh << COLS);
            if (col != 0)                   nbr = nbr | (issue_oh >> 1);
            if (col != COLS - 1)            nbr = nbr | (issue_oh << 1);
        end
        pending_d = pending_q;
        if (sel) pending_d = (pending_q & ~issue_oh) | nbr;
        if (!phase) pending_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end
`else
    logic unused_pships;

    assign unused_pships = ^pships;
    assign use_pend      = 1'b0;
    assign pend_idx      = '0;
`endif

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        idx_d     = idx_q;
        last_d    = last_q;
        guessed_d = guessed_q;
        unique case (state_q)
            IDLE: begin
                if (go && phase && !exhausted) state_d = SEARCH;
            end
            SEARCH: begin
                if (use_pend) begin
                    // queued neighbour: taken at once, LFSR held
                    idx_d   = pend_idx;
                    state_d = ISSUE;
                end else begin
                    lfsr_d = lfsr_nxt;
                    if (cand_ok) begin
                        idx_d   = cand;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = IDLE;
                if (sel) begin
                    guessed_d = guessed_q | issue_oh;
                    last_d    = idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
        // Nothing can mark a cell while phase is low, so clearing here
        // is equivalent to clearing on the falling edge.
        if (!phase) begin
            state_d   = IDLE;
            guessed_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            idx_q     <= '0;
            last_q    <= '0;
            guessed_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            guessed_q <= guessed_d;
        end
    end

endmodule

// File: tb/tb_cpu_guess_generator.sv
// tb_cpu_guess_generator: randomized self-checking bench for
// cpu_guess_generator against a behavioural shot-selection model.
module tb_cpu_guess_generator;

    localparam int          CELLS = 28;
    localparam logic [27:0] FULL  = 28'hFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        phase;
    logic        go;
    logic [27:0] pships;
    logic [27:0] c_curr_guess;
    logic        sel;
    logic        busy;
    logic        exhausted;
    logic [4:0]  last_idx;

    int n_checks  = 0;
    int n_pass    = 0;
    int sel_count = 0;
    bit mon_en    = 1'b0;

    bit [4:0]    m_lfsr;
    bit          m_g[CELLS];
    bit          m_p[CELLS];
    logic [27:0] seen_mask;
    logic [27:0] got3[3];

    always #5 clk = ~clk;

    cpu_guess_generator #(
        .ROWS(4),
        .COLS(7),
        .LFSR_SEED(5'b00001)
    ) dut (
        .clk(clk),
        .rst(rst),
        .phase(phase),
        .go(go),
        .pships(pships),
        .c_curr_guess(c_curr_guess),
        .sel(sel),
        .busy(busy),
        .exhausted(exhausted),
        .last_idx(last_idx)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sel) sel_count++;
            else check("idle_zero", 64'(c_curr_guess), 64'(0));
        end
    end

    function automatic bit [4:0] lfsr_step(input bit [4:0] v);
        return {v[3:0], v[4] ^ v[2]};
    endfunction

    task automatic m_new_game();
        for (int i = 0; i < CELLS; i++) begin
            m_g[i] = 1'b0;
            m_p[i] = 1'b0;
        end
        seen_mask = '0;
    endtask

    task automatic m_reset();
        m_lfsr = 5'b00001;
        m_new_game();
    endtask

    // Which cell is shot next and how many search cycles it takes
    task automatic predict(output int idx, output int srch);
        idx  = -1;
        srch = 0;
`ifdef TARGET_MODE_EN
        for (int i = 0; i < CELLS; i++) begin
            if (idx < 0 && m_p[i] && !m_g[i]) idx = i;
        end
        if (idx >= 0) srch = 1;
`endif
        while (idx < 0 && srch < 40) begin
            int c;
            c      = int'(m_lfsr) - 1;
            m_lfsr = lfsr_step(m_lfsr);
            srch++;
            if (c < CELLS && !m_g[c]) idx = c;
        end
    endtask

    task automatic m_issue(input int idx);
        int r;
        int c;
        r = idx / 7;
        c = idx % 7;
        m_g[idx] = 1'b1;
        m_p[idx] = 1'b0;
        if (pships[idx]) begin
            if (r > 0) m_p[idx - 7] = 1'b1;
            if (r < 3) m_p[idx + 7] = 1'b1;
            if (c > 0) m_p[idx - 1] = 1'b1;
            if (c < 6) m_p[idx + 1] = 1'b1;
        end
    endtask

    // Starts and ends 1 time unit after a rising edge
    task automatic do_guess(input bit dbl, output logic [27:0] got);
        int eidx;
        int esrch;
        int cyc;
        int base;
        logic [63:0] exp_oh;
        predict(eidx, esrch);
        exp_oh = (eidx >= 0) ? (64'(1) << eidx) : 64'(0);
        base = sel_count;
        go = 1'b1;
        @(posedge clk);
        #1;
        cyc = 1;
        if (!dbl) go = 1'b0;
        while (!sel && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            go = 1'b0;
        end
        got = c_curr_guess;
        check("sel_seen", 64'(sel), 64'(1));
        check("latency", 64'(cyc), 64'(esrch + 1));
        check("guess", 64'(c_curr_guess), exp_oh);
        check("onehot", 64'($onehot(c_curr_guess)), 64'(1));
        check("repeat", 64'(c_curr_guess & seen_mask), 64'(0));
        seen_mask = seen_mask | c_curr_guess;
        if (eidx >= 0) m_issue(eidx);
        @(posedge clk);
        #1;
        check("pulse", 64'(sel), 64'(0));
        check("busy_after", 64'(busy), 64'(0));
        check("last_idx", 64'(last_idx), 64'(eidx));
        if (dbl) begin
            repeat (40) @(posedge clk);
            #1;
        end
        check("one_sel", 64'(sel_count - base), 64'(1));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        bit any_busy;
        logic [27:0] g;
        rst    = 1'b0;
        phase  = 1'b0;
        go     = 1'b0;
        pships = '0;
        m_reset();
        mon_en = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_sel", 64'(sel), 64'(0));
        check("rst_guess", 64'(c_curr_guess), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_exh", 64'(exhausted), 64'(0));
        check("rst_last", 64'(last_idx), 64'(0));
        @(posedge clk);
        #1;
        rst   = 1'b0;
        phase = 1'b1;

        for (int i = 0; i < 3; i++) do_guess(1'b0, got3[i]);
        check("t2_g0", 64'(got3[0]), 64'h1);
        check("t2_g1", 64'(got3[1]), 64'h2);
        check("t2_g2", 64'(got3[2]), 64'h8);

        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        check("t1_busy_pre", 64'(busy), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("t1_sel", 64'(sel), 64'(0));
        check("t1_guess", 64'(c_curr_guess), 64'(0));
        check("t1_busy", 64'(busy), 64'(0));
        check("t1_exh", 64'(exhausted), 64'(0));
        check("t1_last", 64'(last_idx), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();

        pships = 28'($urandom());
        for (int i = 0; i < CELLS; i++) begin
            do_guess($urandom_range(0, 3) == 0, g);
            gap();
        end
        check("t3_or", 64'(seen_mask), 64'(FULL));
        check("t3_exh", 64'(exhausted), 64'(1));
        base     = sel_count;
        any_busy = 1'b0;
        go       = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            go = 1'b0;
            if (busy) any_busy = 1'b1;
        end
        check("t3_busy29", 64'(any_busy), 64'(0));
        check("t3_sel29", 64'(sel_count - base), 64'(0));

        phase = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        phase = 1'b1;
        m_new_game();
        check("t4_exh_clr", 64'(exhausted), 64'(0));
        pships = 28'($urandom());
        do_guess(1'b1, g);
        for (int i = 0; i < 6; i++) begin
            gap();
            do_guess($urandom_range(0, 1) == 1, g);
        end

        base = sel_count;
        go   = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        check("t4_busy_srch", 64'(busy), 64'(1));
        phase = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t4_abort_busy", 64'(busy), 64'(0));
        check("t4_abort_sel", 64'(sel_count - base), 64'(0));
        phase = 1'b1;
        #1;
        check("t4_exh_new", 64'(exhausted), 64'(0));
        @(posedge clk);
        #1;
        pulse_reset();

        pships = 28'h0000081;
        for (int i = 0; i < 3; i++) do_guess(1'b0, got3[i]);
        check("t5_g0", 64'(got3[0]), 64'h1);
        check("t5_g1", 64'(got3[1]), 64'h2);
`ifdef TARGET_MODE_EN
        check("t5_g2", 64'(got3[2]), 64'h80);
`else
        check("t5_g2", 64'(got3[2]), 64'h8);
`endif

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
